// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: requester identity,
// arbitration state and the read-tag carried alongside each memory access.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_DMA  = 1'b1
  } owner_t;

  typedef enum logic {
    S_OPEN       = 1'b0,
    S_DMA_LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWNER_CORE};

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Delay line of read tags matching the memory read latency; the output tag
// says who (if anyone) owns the data currently on mem_rd_data.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [RD_LATENCY-1:0] stages;

  // NOTE: unlike a data store, every stage is reset -- a stale valid bit
  // here would fabricate an rd_valid after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) stages[i] <= TAG_IDLE;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[RD_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core (fixed priority) and a DMA/debug
// master, with anti-starvation counting, DMA lock mode and read-data routing.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_wr_ena,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rd_valid,
  output logic [DATA_W-1:0] core_rd_data,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_wr_ena,
  input  logic [DATA_W-1:0] dma_wr_data,
  output logic              dma_gnt,
  output logic              dma_rd_valid,
  output logic [DATA_W-1:0] dma_rd_data,
  input  logic              dma_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_ena,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  // NOTE: every output gets a default first so no path through the
  // conditionals can leave one unassigned and infer a latch.
  always_comb begin
    core_gnt    = 1'b0;
    dma_gnt     = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;

    if (!rst) begin
      if (state == S_DMA_LOCKED) begin
        dma_gnt = dma_req;
      end else if (core_req && dma_req) begin
        // Core wins contention until DMA has waited MAX_WAIT cycles.
        if (wait_cnt == WAIT_SAT) dma_gnt  = 1'b1;
        else                      core_gnt = 1'b1;
      end else begin
        core_gnt = core_req;
        dma_gnt  = dma_req;
      end
    end

    if (core_gnt) begin
      mem_addr    = core_addr;
      mem_wr_data = core_wr_data;
      mem_wr_ena  = core_wr_ena;
    end else if (dma_gnt) begin
      mem_addr    = dma_addr;
      mem_wr_data = dma_wr_data;
      mem_wr_ena  = dma_wr_ena;
    end
  end

  assign core_stall = core_req & ~core_gnt & ~rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OPEN;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_OPEN:       if (dma_gnt && dma_lock) state <= S_DMA_LOCKED;
        S_DMA_LOCKED: if (!dma_lock)           state <= S_OPEN;
        default:                               state <= S_OPEN;
      endcase

      if (dma_gnt || !dma_req)
        wait_cnt <= '0;
      else if (state == S_OPEN && wait_cnt != WAIT_SAT)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    tag_in       = TAG_IDLE;
    tag_in.valid = (core_gnt | dma_gnt) & ~mem_wr_ena;
    tag_in.owner = dma_gnt ? OWNER_DMA : OWNER_CORE;
  end

  mem_arb_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign core_rd_valid = tag_out.valid & ~rst & (tag_out.owner == OWNER_CORE);
  assign dma_rd_valid  = tag_out.valid & ~rst & (tag_out.owner == OWNER_DMA);
  assign core_rd_data  = mem_rd_data;
  assign dma_rd_data   = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (read latency 1 and 2)
// share the stimulus, each with its own behavioural memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_wr_ena, dma_req, dma_wr_ena, dma_lock;
  logic [31:0] core_addr, core_wr_data, dma_addr, dma_wr_data;

  logic        c_gnt1, c_stall1, c_rdv1, d_gnt1, d_rdv1, m_we1;
  logic [31:0] c_rdd1, d_rdd1, m_addr1, m_wd1, m_rd1;
  logic        c_gnt2, c_stall2, c_rdv2, d_gnt2, d_rdv2, m_we2;
  logic [31:0] c_rdd2, d_rdd2, m_addr2, m_wd2, m_rd2;

  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] rd2_stage;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LATENCY(1), .MAX_WAIT(4)) dut1 (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_addr(core_addr), .core_wr_ena(core_wr_ena),
    .core_wr_data(core_wr_data), .core_gnt(c_gnt1), .core_stall(c_stall1),
    .core_rd_valid(c_rdv1), .core_rd_data(c_rdd1),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wr_ena(dma_wr_ena),
    .dma_wr_data(dma_wr_data), .dma_gnt(d_gnt1), .dma_rd_valid(d_rdv1),
    .dma_rd_data(d_rdd1), .dma_lock(dma_lock),
    .mem_addr(m_addr1), .mem_wr_data(m_wd1), .mem_wr_ena(m_we1), .mem_rd_data(m_rd1)
  );

  mem_port_arbiter #(.RD_LATENCY(2), .MAX_WAIT(4)) dut2 (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_addr(core_addr), .core_wr_ena(core_wr_ena),
    .core_wr_data(core_wr_data), .core_gnt(c_gnt2), .core_stall(c_stall2),
    .core_rd_valid(c_rdv2), .core_rd_data(c_rdd2),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wr_ena(dma_wr_ena),
    .dma_wr_data(dma_wr_data), .dma_gnt(d_gnt2), .dma_rd_valid(d_rdv2),
    .dma_rd_data(d_rdd2), .dma_lock(dma_lock),
    .mem_addr(m_addr2), .mem_wr_data(m_wd2), .mem_wr_ena(m_we2), .mem_rd_data(m_rd2)
  );

  // Word-addressed memories: word i holds 0xA000_0000 + i until written.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'hA000_0000 + i;
      mem2[i] = 32'hA000_0000 + i;
    end
  end

  always @(posedge clk) begin
    m_rd1 <= mem1[m_addr1[9:2]];
    if (m_we1) mem1[m_addr1[9:2]] <= m_wd1;
    rd2_stage <= mem2[m_addr2[9:2]];
    m_rd2     <= rd2_stage;
    if (m_we2) mem2[m_addr2[9:2]] <= m_wd2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic req, input logic [31:0] addr, input logic we, input logic [31:0] wd);
    core_req = req; core_addr = addr; core_wr_ena = we; core_wr_data = wd;
  endtask

  task automatic set_dma(input logic req, input logic [31:0] addr, input logic we, input logic [31:0] wd,
                         input logic lock);
    dma_req = req; dma_addr = addr; dma_wr_ena = we; dma_wr_data = wd; dma_lock = lock;
  endtask

  initial begin
    rst = 1'b1;
    set_core(1'b1, 32'h10, 1'b0, 32'h0);
    set_dma(1'b1, 32'h30, 1'b1, 32'h1234, 1'b1);

    // Reset: requests present but every output held low.
    tick(); #1;
    check("rst_core_gnt",   32'(c_gnt1),   32'h0);
    check("rst_dma_gnt",    32'(d_gnt1),   32'h0);
    check("rst_core_stall", 32'(c_stall1), 32'h0);
    check("rst_mem_we",     32'(m_we1),    32'h0);
    check("rst_mem_addr",   m_addr1,       32'h0);
    check("rst_mem_wd",     m_wd1,         32'h0);
    tick();
    rst = 1'b0;
    set_core(1'b0, 32'h0, 1'b0, 32'h0);
    set_dma(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("idle_mem_addr", m_addr1, 32'h0);
    check("idle_rdv",      32'({c_rdv1, d_rdv1}), 32'h0);

    // 1: core-only back-to-back reads.
    tick(); set_core(1'b1, 32'h10, 1'b0, 32'h0); #1;
    check("t1_gnt0",  32'(c_gnt1), 32'h1);
    check("t1_addr0", m_addr1,     32'h10);
    check("t1_rdv0",  32'(c_rdv1), 32'h0);
    tick(); set_core(1'b1, 32'h14, 1'b0, 32'h0); #1;
    check("t1_gnt1",   32'(c_gnt1), 32'h1);
    check("t1_stall1", 32'(c_stall1), 32'h0);
    check("t1_rdv1",   32'(c_rdv1), 32'h1);
    check("t1_rdd1",   c_rdd1,      32'hA000_0004);
    check("t1_drdv1",  32'(d_rdv1), 32'h0);
    check("t1_lat2_early", 32'(c_rdv2), 32'h0);
    tick(); set_core(1'b0, 32'h0, 1'b0, 32'h0); #1;
    check("t1_rdv2",  32'(c_rdv1), 32'h1);
    check("t1_rdd2",  c_rdd1,      32'hA000_0005);
    check("t1_drdv2", 32'(d_rdv1), 32'h0);
    check("t1_lat2_rdv", 32'(c_rdv2), 32'h1);
    check("t1_lat2_rdd", c_rdd2,      32'hA000_0004);
    tick(); #1;
    check("t1_rdv3", 32'(c_rdv1), 32'h0);
    check("t1_lat2_rdv3", 32'(c_rdv2), 32'h1);
    check("t1_lat2_rdd3", c_rdd2,      32'hA000_0005);

    // 2: continuous contention -> core 4 grants, DMA 1, repeating.
    for (int k = 0; k < 10; k++) begin
      tick();
      set_core(1'b1, 32'h20, 1'b0, 32'h0);
      set_dma(1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
      #1;
      check($sformatf("t2_core_gnt_%0d", k),  32'(c_gnt1),   32'((k % 5) != 4));
      check($sformatf("t2_dma_gnt_%0d", k),   32'(d_gnt1),   32'((k % 5) == 4));
      check($sformatf("t2_stall_%0d", k),     32'(c_stall1), 32'((k % 5) == 4));
      check($sformatf("t2_dma_rdv_%0d", k),   32'(d_rdv1),   32'(k > 0 && (k % 5) == 0));
      check($sformatf("t2_core_rdv_%0d", k),  32'(c_rdv1),   32'(k > 0 && (k % 5) != 0));
    end
    tick(); set_core(1'b0, 32'h0, 1'b0, 32'h0); set_dma(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // 3: DMA wins uncontended with lock, then holds lock against the core.
    tick(); set_dma(1'b1, 32'h30, 1'b0, 32'h0, 1'b1); #1;
    check("t3_lock_gnt", 32'(d_gnt1), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick(); set_core(1'b1, 32'h20, 1'b0, 32'h0); #1;
      check($sformatf("t3_core_gnt_%0d", k), 32'(c_gnt1),   32'h0);
      check($sformatf("t3_stall_%0d", k),    32'(c_stall1), 32'h1);
      check($sformatf("t3_dma_gnt_%0d", k),  32'(d_gnt1),   32'h1);
    end
    tick(); set_dma(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    check("t3_drop_core_gnt", 32'(c_gnt1),   32'h0);
    check("t3_drop_stall",    32'(c_stall1), 32'h1);
    tick(); #1;
    check("t3_after_core_gnt", 32'(c_gnt1),   32'h1);
    check("t3_after_stall",    32'(c_stall1), 32'h0);
    tick(); set_core(1'b0, 32'h0, 1'b0, 32'h0);

    // 4: core read / DMA write / DMA read, interleaved.
    tick(); set_core(1'b1, 32'h50, 1'b0, 32'h0); #1;
    check("t4_a_we", 32'(m_we1), 32'h0);
    tick(); set_core(1'b0, 32'h0, 1'b0, 32'h0); set_dma(1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF, 1'b0); #1;
    check("t4_b_we",    32'(m_we1), 32'h1);
    check("t4_b_addr",  m_addr1,    32'h40);
    check("t4_b_wd",    m_wd1,      32'hDEAD_BEEF);
    check("t4_b_crdv",  32'(c_rdv1), 32'h1);
    check("t4_b_crdd",  c_rdd1,      32'hA000_0014);
    check("t4_b_drdv",  32'(d_rdv1), 32'h0);
    tick(); set_dma(1'b1, 32'h40, 1'b0, 32'h0, 1'b0); #1;
    check("t4_c_we",    32'(m_we1), 32'h0);
    check("t4_c_gnt",   32'(d_gnt1), 32'h1);
    check("t4_c_rdv",   32'({c_rdv1, d_rdv1}), 32'h0);
    tick(); set_dma(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    check("t4_d_drdv",  32'(d_rdv1), 32'h1);
    check("t4_d_drdd",  d_rdd1,      32'hDEAD_BEEF);
    check("t4_d_crdv",  32'(c_rdv1), 32'h0);

    // 6: lock request while DMA is denied has no effect.
    for (int k = 0; k < 3; k++) begin
      tick(); set_core(1'b1, 32'h20, 1'b0, 32'h0); set_dma(1'b1, 32'h30, 1'b0, 32'h0, 1'b1); #1;
      check($sformatf("t6_core_gnt_%0d", k), 32'(c_gnt1), 32'h1);
      check($sformatf("t6_dma_gnt_%0d", k),  32'(d_gnt1), 32'h0);
    end
    tick(); set_dma(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    check("t6_state",    32'(dut1.state), 32'(S_OPEN));
    check("t6_core_gnt", 32'(c_gnt1),     32'h1);
    tick(); set_core(1'b0, 32'h0, 1'b0, 32'h0);

    // 5: reset one cycle after a read grant, latency 2.
    tick(); set_core(1'b1, 32'h10, 1'b0, 32'h0); set_dma(1'b1, 32'h30, 1'b0, 32'h0, 1'b0); #1;
    check("t5_gnt", 32'(c_gnt2), 32'h1);
    tick(); rst = 1'b1; #1;
    check("t5_rst_gnt",   32'({c_gnt2, d_gnt2}), 32'h0);
    check("t5_rst_stall", 32'(c_stall2), 32'h0);
    check("t5_rst_rdv",   32'({c_rdv2, d_rdv2}), 32'h0);
    check("t5_rst_mem",   32'({m_we2, |m_addr2, |m_wd2}), 32'h0);
    tick(); rst = 1'b0; set_core(1'b0, 32'h0, 1'b0, 32'h0); set_dma(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); #1;
    check("t5_post_rdv0", 32'({c_rdv2, d_rdv2}), 32'h0);
    check("t5_state",     32'(dut2.state),    32'(S_OPEN));
    check("t5_wait_cnt",  32'(dut2.wait_cnt), 32'h0);
    tick(); #1;
    check("t5_post_rdv1", 32'({c_rdv2, d_rdv2}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
